// File: rtl/uart_pkg.sv
// Shared definitions for both ends of the serial link: FSM state encoding and
// frame geometry constants.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side load handshake and serial-side outputs of the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    // A byte transfers on a rising edge where load and ready are both high.
    // ready never depends on load.
    logic [DATA_BITS-1:0] data;
    logic                 load;
    logic                 ready;
    logic                 txd;
    logic                 charSent;

    modport master (output data, load, input ready, txd, charSent);
    modport slave  (input data, load, output ready, txd, charSent);

endinterface

// File: rtl/tx_bit_timer.sv
// Bit-period timer: bitDone pulses on the last clock of every CLKS_PER_BIT-clock
// bit while run is high; the count is held at zero while run is low.
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bitDone
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bitDone = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!run || bitDone) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8-N-1 UART transmitter: accepts a byte on the load/ready handshake and
// serialises start bit, eight data bits LSB first, and stop bit onto txd.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  tx_if,
    output tx_state_e state_o
);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 txd_q, txd_d;
    logic                 bit_done;
    logic                 run;
    logic                 accept;

    assign run      = (state_q != IDLE);
    assign state_o  = state_q;
    assign tx_if.txd = txd_q;

    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .bitDone (bit_done)
    );

    // txd_d is the line level for the cycle after the edge, so txd is registered.
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        txd_d          = txd_q;
        tx_if.ready    = 1'b0;
        tx_if.charSent = 1'b0;
        accept         = 1'b0;

        case (state_q)
            IDLE: begin
                tx_if.ready = 1'b1;
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    txd_d     = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        txd_d     = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    tx_if.ready    = 1'b1;
                    tx_if.charSent = 1'b1;
                    state_d        = IDLE;
                    txd_d          = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Acceptance in the final stop cycle chains straight into the next start bit.
        accept = tx_if.ready && tx_if.load;
        if (accept) begin
            state_d   = START;
            shift_d   = tx_if.data;
            bit_cnt_d = '0;
            txd_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (2, 4 and 16 clocks per bit) share one
// stimulus stream and are checked every cycle against a frame-offset model.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int N_INST = 3;

    logic       clk;
    logic       rst;
    logic       load_s;
    logic [7:0] data_s;

    int tests;
    int fails;

    uart_tx_if if_c2 ();
    uart_tx_if if_c4 ();
    uart_tx_if if_c16 ();

    tx_state_e st_c2, st_c4, st_c16;

    assign if_c2.data  = data_s;
    assign if_c2.load  = load_s;
    assign if_c4.data  = data_s;
    assign if_c4.load  = load_s;
    assign if_c16.data = data_s;
    assign if_c16.load = load_s;

    uart_tx #(.CLKS_PER_BIT(2))  u_dut_c2  (.clk(clk), .rst(rst), .tx_if(if_c2.slave),  .state_o(st_c2));
    uart_tx #(.CLKS_PER_BIT(4))  u_dut_c4  (.clk(clk), .rst(rst), .tx_if(if_c4.slave),  .state_o(st_c4));
    uart_tx #(.CLKS_PER_BIT(16)) u_dut_c16 (.clk(clk), .rst(rst), .tx_if(if_c16.slave), .state_o(st_c16));

    logic [2:0] txd_w, ready_w, cs_w;
    assign txd_w   = {if_c16.txd, if_c4.txd, if_c2.txd};
    assign ready_w = {if_c16.ready, if_c4.ready, if_c2.ready};
    assign cs_w    = {if_c16.charSent, if_c4.charSent, if_c2.charSent};

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is 10*C cycles; offset o within it carries bit o/C of
    // {stop, data[7:0], start}. ready/charSent are tied to the last offset.
    int         cpb [N_INST] = '{2, 4, 16};
    logic       m_busy [N_INST];
    int         m_off  [N_INST];
    logic [7:0] m_byte [N_INST];
    logic [7:0] exp_q[$];
    logic       m_accept;
    int         m_last;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_INST; i++) begin
                m_busy[i] = 1'b0;
                m_off[i]  = 0;
            end
            exp_q.delete();
        end else begin
            for (int i = 0; i < N_INST; i++) begin
                m_last   = 10 * cpb[i] - 1;
                m_accept = load_s && (!m_busy[i] || m_off[i] == m_last);
                if (m_accept) begin
                    m_busy[i] = 1'b1;
                    m_off[i]  = 0;
                    m_byte[i] = data_s;
                    if (i == 1) exp_q.push_back(data_s);
                end else if (m_busy[i]) begin
                    if (m_off[i] == m_last) m_busy[i] = 1'b0;
                    else m_off[i] = m_off[i] + 1;
                end
            end
        end
    end

    function automatic logic exp_txd(input int i);
        int b;
        if (!m_busy[i]) return 1'b1;
        b = m_off[i] / cpb[i];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_byte[i][b-1];
    endfunction

    function automatic logic exp_last(input int i);
        return m_busy[i] && (m_off[i] == 10 * cpb[i] - 1);
    endfunction

    // ---------------- per-cycle compare + scoreboard ----------------
    logic [7:0] rx_byte;
    int         rx_bit;

    always @(negedge clk) begin
        for (int i = 0; i < N_INST; i++) begin
            check($sformatf("txd_c%0d", cpb[i]),   32'(txd_w[i]),   32'(exp_txd(i)));
            check($sformatf("ready_c%0d", cpb[i]), 32'(ready_w[i]), 32'(!m_busy[i] || exp_last(i)));
            check($sformatf("cs_c%0d", cpb[i]),    32'(cs_w[i]),    32'(exp_last(i)));
        end
        if (m_busy[1] && (m_off[1] % 4 == 2)) begin
            rx_bit = m_off[1] / 4;
            if (rx_bit >= 1 && rx_bit <= 8) rx_byte[rx_bit-1] = txd_w[1];
        end
        if (cs_w[1]) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_byte: got charSent with byte %0h, expected no frame", rx_byte);
            end else begin
                check("sb_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_one(input logic [7:0] b);
        @(negedge clk);
        load_s = 1'b1;
        data_s = b;
        @(negedge clk);
        load_s = 1'b0;
    endtask

    task automatic count_cs(input int cycles, output int cnt [N_INST]);
        cnt = '{0, 0, 0};
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            for (int i = 0; i < N_INST; i++) if (cs_w[i]) cnt[i]++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic sc_reset();
        rst    = 1'b0;
        load_s = 1'b1;
        data_s = 8'hA5;
        repeat (4) @(negedge clk);
        check("rst_txd", 32'(txd_w), 32'h7);
        check("rst_ready", 32'(ready_w), 32'h7);
        check("rst_cs", 32'(cs_w), 32'h0);
        load_s = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_idle_txd", 32'(txd_w), 32'h7);
    endtask

    task automatic sc_single();
        int pat [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        int seen [N_INST];
        seen = '{0, 0, 0};
        load_one(8'hA5);
        for (int n = 1; n <= 170; n++) begin
            if (n > 1) @(negedge clk);
            if (n <= 40) check($sformatf("a5_txd_c4_n%0d", n), 32'(txd_w[1]), 32'(pat[(n-1)/4]));
            if (n == 39) check("a5_ready_n39", 32'(ready_w[1]), 32'h0);
            if (n == 40) check("a5_ready_n40", 32'(ready_w[1]), 32'h1);
            for (int i = 0; i < N_INST; i++) if (cs_w[i] && seen[i] == 0) seen[i] = n;
        end
        check("frame_len_c2", 32'(seen[0]), 32'd20);
        check("frame_len_c4", 32'(seen[1]), 32'd40);
        check("frame_len_c16", 32'(seen[2]), 32'd160);
    endtask

    task automatic sc_busy();
        int cnt [N_INST];
        load_one(8'h3C);
        repeat (9) @(negedge clk);
        load_s = 1'b1;
        data_s = 8'hFF;
        @(negedge clk);
        load_s = 1'b0;
        count_cs(170, cnt);
        check("busy_cs_c2", 32'(cnt[0]), 32'd1);
        check("busy_cs_c4", 32'(cnt[1]), 32'd1);
        check("busy_cs_c16", 32'(cnt[2]), 32'd1);
        check("busy_idle_txd", 32'(txd_w), 32'h7);
    endtask

    task automatic sc_b2b();
        int first, second;
        int cnt [N_INST];
        first  = 0;
        second = 0;
        @(negedge clk);
        load_s = 1'b1;
        data_s = 8'h00;
        @(negedge clk);
        data_s = 8'hFF;
        for (int n = 1; n <= 60; n++) begin
            if (n > 1) @(negedge clk);
            if (cs_w[1]) begin
                first = n;
                break;
            end
        end
        check("b2b_first_cs", 32'(first), 32'd40);
        @(negedge clk);
        load_s = 1'b0;
        check("b2b_no_gap_txd", 32'(txd_w[1]), 32'h0);
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (cs_w[1]) begin
                second = k;
                break;
            end
        end
        check("b2b_cs_spacing", 32'(second), 32'd40);
        count_cs(170, cnt);
    endtask

    task automatic sc_mid_reset();
        int cnt [N_INST];
        load_one(8'h55);
        repeat (17) @(negedge clk);
        check("mid_pre_rst_txd", 32'(txd_w[1]), 32'h0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_async_txd", 32'(txd_w), 32'h7);
        check("mid_rst_cs", 32'(cs_w), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        count_cs(40, cnt);
        check("mid_no_cs_c4", 32'(cnt[1]), 32'd0);
        check("mid_no_cs_c16", 32'(cnt[2]), 32'd0);
        load_one(8'h81);
        count_cs(170, cnt);
        check("after_rst_cs_c4", 32'(cnt[1]), 32'd1);
        check("after_rst_cs_c16", 32'(cnt[2]), 32'd1);
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst    = 1'b0;
        load_s = 1'b0;
        data_s = 8'h00;
        sc_reset();
        sc_single();
        sc_busy();
        sc_b2b();
        sc_mid_reset();
        repeat (4) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
